// File: rtl/group_popcount_argmax_pkg.sv
// Shared constants, types and FSM states for the group popcount / argmax stage.
// The typedefs describe the default configuration; parameterised instances size their own signals.
package dlgn_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int GROUP_SIZE_DEF  = 8;
  localparam int CLS_W_DEF       = $clog2(NUM_CLASSES_DEF);
  localparam int SCORE_W_DEF     = $clog2(GROUP_SIZE_DEF + 1);

  typedef logic [CLS_W_DEF-1:0]   class_idx_t;
  typedef logic [SCORE_W_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_e;

endpackage

// File: rtl/group_popcount_argmax_popcount.sv
// Combinational population count of a WIDTH-bit slice.
// The output is sized so that an all-ones input cannot overflow.
module popcount #(
  parameter  int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [OUT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/group_popcount_argmax.sv
// Splits the gate-layer vector into class groups, popcounts one group per cycle and
// emits the index and score of the best group as a single-cycle valid pulse.
module group_popcount_argmax
  import dlgn_pkg::*;
#(
  parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter  int GROUP_SIZE  = GROUP_SIZE_DEF,
  localparam int CLS_W       = $clog2(NUM_CLASSES),
  localparam int SCORE_W     = $clog2(GROUP_SIZE + 1),
  localparam int VEC_W       = NUM_CLASSES * GROUP_SIZE
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               inp_valid_i,
  output logic               inp_ready_o,
  input  logic [VEC_W-1:0]   gates_i,
  output logic               class_valid_o,
  output logic [CLS_W-1:0]   class_o,
  output logic [SCORE_W-1:0] score_o
);

  if (GROUP_SIZE < 1 || NUM_CLASSES < 2) begin : g_bad_params
    $error("group_popcount_argmax: need GROUP_SIZE >= 1 and NUM_CLASSES >= 2");
  end

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  argmax_state_e        r_state;
  logic [VEC_W-1:0]     r_vec;
  logic [CLS_W-1:0]     r_idx;
  logic [CLS_W-1:0]     r_best_cls;
  logic [SCORE_W-1:0]   r_best_score;
  logic                 r_ready;
  logic                 r_class_valid;
  logic [CLS_W-1:0]     r_class;
  logic [SCORE_W-1:0]   r_score;

  logic [GROUP_SIZE-1:0] w_group;
  logic [SCORE_W-1:0]    w_cnt;

  // Explicit compare-select keeps the slice index inside the vector for non power-of-2 class counts.
  always_comb begin
    w_group = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (r_idx == CLS_W'(k)) begin
        w_group = r_vec[k*GROUP_SIZE +: GROUP_SIZE];
      end
    end
  end

  popcount #(
    .WIDTH (GROUP_SIZE)
  ) u_popcount (
    .i_bits  (w_group),
    .o_count (w_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state       <= IDLE;
      r_vec         <= '0;
      r_idx         <= '0;
      r_best_cls    <= '0;
      r_best_score  <= '0;
      r_ready       <= 1'b1;
      r_class_valid <= 1'b0;
      r_class       <= '0;
      r_score       <= '0;
    end else begin
      r_class_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (inp_valid_i && r_ready) begin
            r_vec        <= gates_i;
            r_idx        <= '0;
            r_best_cls   <= '0;
            r_best_score <= '0;
            r_ready      <= 1'b0;
            r_state      <= SCAN;
          end
        end
        SCAN: begin
          // Strict greater-than so the lowest index keeps a tie.
          if (r_idx == '0 || w_cnt > r_best_score) begin
            r_best_cls   <= r_idx;
            r_best_score <= w_cnt;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_class       <= r_best_cls;
          r_score       <= r_best_score;
          r_class_valid <= 1'b1;
          r_ready       <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign inp_ready_o   = r_ready;
  assign class_valid_o = r_class_valid;
  assign class_o       = r_class;
  assign score_o       = r_score;

endmodule
